// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the oversample ratio
// common to the transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every DVSR clocks, restartable via clr
// so a new frame always begins on a fresh tick period.
module uart_baud_gen #(
    parameter int DVSR = 54
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DVSR > 2) ? $clog2(DVSR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DVSR - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from a first-word-fall-through FIFO and frames them
// start/data LSB-first/[parity]/stop. Define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int DVSR      = 54,
    parameter int SB_TICK   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 empty,
    input  logic [DATA_BITS-1:0] r_data,
    output logic                 rd,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done_tick
);

    import uart_pkg::*;

    localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [4:0]    OS_LAST   = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]    STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DATA_BITS - 1);

    uart_tx_state_t       state_q, state_d;
    logic [4:0]           s_q, s_d;
    logic [NW-1:0]        n_q, n_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 clr;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    uart_baud_gen #(.DVSR(DVSR)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        rd      = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                // Pop is gated by reset so the FIFO never loses a word the FSM cannot take.
                if (!empty && !reset) begin
                    rd      = 1'b1;
                    shift_d = r_data;
                    s_d     = '0;
                    n_d     = '0;
                    clr     = 1'b1;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^r_data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == OS_LAST) begin
                        s_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == OS_LAST) begin
                        s_d     = '0;
                        shift_d = shift_q >> 1;
                        if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_q == OS_LAST) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_q == STOP_LAST) begin
                        s_d     = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the state being entered, so tx changes on the same edge as the state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx           = tx_q;
    assign busy         = (state_q != IDLE);
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: FIFO model, serial-line sampler and expected-frame scoreboard.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int DVSR      = 4;
    localparam int SB_TICK   = 16;
    localparam int BIT_CLK   = 16 * DVSR;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB        = 10 + P;
    localparam int FRAME_LEN = (1 + 8 + P) * BIT_CLK + SB_TICK * DVSR;
    localparam int NV        = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rd, tx, busy, tx_done_tick;

    uart_tx #(.DATA_BITS(8), .DVSR(DVSR), .SB_TICK(SB_TICK)) dut (
        .clk          (clk),
        .reset        (reset),
        .empty        (empty),
        .r_data       (r_data),
        .rd           (rd),
        .tx           (tx),
        .busy         (busy),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    vec_t       tbl[NV];
    vec_t       exp_q[$];
    logic [7:0] fifo_q[$];

    int checks = 0, failures = 0;
    int cyc = 0, rd_cnt = 0, done_cnt = 0, b2b_cnt = 0, rd_busy_viol = 0;
    int fall_cyc = 0, done_cyc = -100;
    int mon_cnt = 0, k = 0;
    logic       mon_busy = 1'b0;
    logic       rd_pop = 1'b0;
    logic [9:0] cap = '0;
    logic       cap_par = 1'b0;
    vec_t       v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic update_fifo();
        empty  = (fifo_q.size() == 0);
        r_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    task automatic push_vec(input vec_t pv);
        fifo_q.push_back(pv.data);
        exp_q.push_back(pv);
        update_fifo();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy !== 1'b0 || fifo_q.size() != 0 || mon_busy) && n < budget);
        check("idle_within_budget", (n < budget), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_busy(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("busy_within_budget", (n < budget), 1);
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rd_pop <= rd;
    end

    // FIFO pop, pulse counters and serial sampler, all away from the active edge.
    always @(negedge clk) begin
        if (rd_pop) begin
            rd_cnt++;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            update_fifo();
        end
        if (rd === 1'b1 && busy === 1'b1) rd_busy_viol++;
        if (tx_done_tick === 1'b1) begin
            done_cnt++;
            check("frame_len", cyc - fall_cyc, FRAME_LEN);
            done_cyc = cyc;
        end
        if (reset) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
                fall_cyc = cyc;
                if (cyc - done_cyc == 1) b2b_cnt++;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % BIT_CLK == BIT_CLK / 2) begin
                k = mon_cnt / BIT_CLK;
                if (k <= 8) begin
                    cap[k] = tx;
                end else if (k == NB - 1) begin
                    cap[9]   = tx;
                    mon_busy = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame: got %0h expected none", cap);
                    end else begin
                        v = exp_q.pop_front();
                        check("frame", cap, v.frame);
`ifdef UART_TX_PARITY_EN
                        check("parity", cap_par, v.par);
`endif
                    end
                end else begin
                    cap_par = tx;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int viol, r0, d0, b0;
        tbl[0] = '{8'hA5, 10'b1101001010, 1'b0};
        tbl[1] = '{8'h00, 10'b1000000000, 1'b0};
        tbl[2] = '{8'hFF, 10'b1111111110, 1'b0};
        tbl[3] = '{8'h3C, 10'b1001111000, 1'b0};
        tbl[4] = '{8'h07, 10'b1000001110, 1'b1};
        tbl[5] = '{8'h03, 10'b1000000110, 1'b0};
        tbl[6] = '{8'h55, 10'b1010101010, 1'b0};
        tbl[7] = '{8'h81, 10'b1100000010, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_rd", rd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done_tick, 0);
        #2 reset = 1'b0;

        viol = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || rd !== 1'b0 || busy !== 1'b0 || tx_done_tick !== 1'b0) viol++;
        end
        check("idle_1000", viol, 0);

        for (int i = 0; i < NV; i++) begin
            r0 = rd_cnt;
            d0 = done_cnt;
            @(negedge clk);
            #2 push_vec(tbl[i]);
            #1 check("rd_comb", rd, 1);
            @(posedge clk);
            #1 check("start_latency_tx", tx, 0);
            check("start_busy", busy, 1);
            wait_idle(3000);
            check("rd_pulses", rd_cnt - r0, 1);
            check("done_pulses", done_cnt - d0, 1);
            check("fifo_drained", empty, 1);
        end

        r0 = rd_cnt;
        d0 = done_cnt;
        b0 = b2b_cnt;
        @(negedge clk);
        #2 push_vec(tbl[1]);
        push_vec(tbl[2]);
        push_vec(tbl[3]);
        wait_idle(6000);
        check("burst_rd", rd_cnt - r0, 3);
        check("burst_done", done_cnt - d0, 3);
        check("burst_gap1", b2b_cnt - b0, 2);

        r0 = rd_cnt;
        @(negedge clk);
        #2 push_vec(tbl[6]);
        wait_busy(100);
        repeat (BIT_CLK + 200) @(negedge clk);
        #2 push_vec(tbl[7]);
        #1 check("rd_blocked_in_frame", rd, 0);
        d0 = done_cnt;
        @(negedge clk);
        #2 reset = 1'b1;
        void'(exp_q.pop_front());
        @(posedge clk);
        #1 check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_rd", rd, 0);
        repeat (5) @(negedge clk);
        check("abort_rd_cnt", rd_cnt - r0, 1);
        #2 reset = 1'b0;
        wait_idle(3000);
        check("abort_no_done", done_cnt - d0, 1);
        check("after_abort_rd", rd_cnt - r0, 2);

        r0 = rd_cnt;
        b0 = b2b_cnt;
        @(negedge clk);
        #2 push_vec(tbl[0]);
        wait_busy(100);
        repeat (100) @(negedge clk);
        #2 push_vec(tbl[4]);
        #1 check("rd_held_midframe", rd, 0);
        wait_idle(3000);
        check("midframe_rd", rd_cnt - r0, 2);
        check("midframe_gap1", b2b_cnt - b0, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        check("rd_while_busy", rd_busy_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
